// File: rtl/trap_ctrl.sv
// Machine-mode trap/MRET sequencer: walks the CSR file's single port, then strobes a one-cycle PC redirect.
// Optional build macro TRAP_VECTORED_EN enables mtvec vectored mode for interrupts.
module trap_ctrl #(
  parameter int XLEN   = 32,
  parameter int RD_LAT = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            exc_valid_i,
  input  logic [XLEN-1:0] exc_cause_i,
  input  logic [XLEN-1:0] exc_pc_i,
  input  logic            mret_i,
  output logic            busy_o,
  output logic            redirect_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic [XLEN-1:0] csr_addr_o,
  output logic            csr_wr_o,
  output logic            csr_rd_o,
  output logic [XLEN-1:0] csr_wdata_o,
  output logic            csr_except_o,
  input  logic [XLEN-1:0] csr_rdata_i
);

  localparam logic [XLEN-1:0] CSR_MSTATUS = XLEN'(12'h300);
  localparam logic [XLEN-1:0] CSR_MTVEC   = XLEN'(12'h305);
  localparam logic [XLEN-1:0] CSR_MEPC    = XLEN'(12'h341);
  localparam logic [XLEN-1:0] CSR_MCAUSE  = XLEN'(12'h342);

  // Capture states sit exactly one cycle after their read, matching the CSR file's registered read.
  if (RD_LAT != 1) begin : g_rd_lat_check
    $error("trap_ctrl: only RD_LAT=1 is supported");
  end

  typedef enum logic [3:0] {
    S_IDLE,
    S_T_RD_MST,
    S_T_WR_MEPC,
    S_T_WR_MCAUSE,
    S_T_WR_MST,
    S_T_RD_MTVEC,
    S_T_CAP_MTVEC,
    S_R_RD_MST,
    S_R_RD_MEPC,
    S_R_CAP_MEPC,
    S_R_WR_MST,
    S_REDIRECT
  } state_e;

  state_e          r_state;
  state_e          w_state_nxt;
  logic [XLEN-1:0] r_cause;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_mst;
  logic [XLEN-1:0] r_tvec;
  logic [XLEN-1:0] w_mst_trap;
  logic [XLEN-1:0] w_mst_ret;
  logic [XLEN-1:0] w_trap_pc;

  logic            w_busy_nxt;
  logic            w_redirect_nxt;
  logic [XLEN-1:0] w_redirect_pc_nxt;
  logic [XLEN-1:0] w_addr_nxt;
  logic            w_wr_nxt;
  logic            w_rd_nxt;
  logic [XLEN-1:0] w_wdata_nxt;
  logic            w_except_nxt;

  logic            w_unused;
  assign w_unused = ^{r_pc[1:0], r_tvec[1:0]};

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (exc_valid_i) w_state_nxt = S_T_RD_MST;
        else if (mret_i) w_state_nxt = S_R_RD_MST;
      end
      S_T_RD_MST:    w_state_nxt = S_T_WR_MEPC;
      S_T_WR_MEPC:   w_state_nxt = S_T_WR_MCAUSE;
      S_T_WR_MCAUSE: w_state_nxt = S_T_WR_MST;
      S_T_WR_MST:    w_state_nxt = S_T_RD_MTVEC;
      S_T_RD_MTVEC:  w_state_nxt = S_T_CAP_MTVEC;
      S_T_CAP_MTVEC: w_state_nxt = S_REDIRECT;
      S_R_RD_MST:    w_state_nxt = S_R_RD_MEPC;
      S_R_RD_MEPC:   w_state_nxt = S_R_CAP_MEPC;
      S_R_CAP_MEPC:  w_state_nxt = S_R_WR_MST;
      S_R_WR_MST:    w_state_nxt = S_REDIRECT;
      S_REDIRECT:    w_state_nxt = S_IDLE;
      default:       w_state_nxt = S_IDLE;
    endcase
  end

  // Request capture plus the two CSR read captures (mstatus, then mtvec or mepc).
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_cause <= '0;
      r_pc    <= '0;
      r_mst   <= '0;
      r_tvec  <= '0;
    end else begin
      if (r_state == S_IDLE && exc_valid_i) begin
        r_cause <= exc_cause_i;
        r_pc    <= exc_pc_i;
      end
      if (r_state == S_T_WR_MEPC || r_state == S_R_RD_MEPC) r_mst <= csr_rdata_i;
      if (r_state == S_T_CAP_MTVEC || r_state == S_R_CAP_MEPC) r_tvec <= csr_rdata_i;
    end
  end

  always_comb begin
    w_mst_trap        = r_mst;
    w_mst_trap[7]     = r_mst[3];
    w_mst_trap[3]     = 1'b0;
    w_mst_trap[12:11] = 2'b11;

    w_mst_ret         = r_mst;
    w_mst_ret[3]      = r_mst[7];
    w_mst_ret[7]      = 1'b1;
    w_mst_ret[12:11]  = 2'b11;
  end

  // The redirect flop loads while mtvec is still on csr_rdata_i, so the target is formed from it directly.
  always_comb begin
    w_trap_pc = {csr_rdata_i[XLEN-1:2], 2'b00};
`ifdef TRAP_VECTORED_EN
    if (csr_rdata_i[1:0] == 2'b01 && r_cause[XLEN-1])
      w_trap_pc = w_trap_pc + XLEN'({r_cause[4:0], 2'b00});
`endif
  end

  // Outputs are decoded from the next state and registered, so each lines up with its state.
  always_comb begin
    w_busy_nxt        = (w_state_nxt != S_IDLE);
    w_redirect_nxt    = 1'b0;
    w_redirect_pc_nxt = '0;
    w_addr_nxt        = '0;
    w_wr_nxt          = 1'b0;
    w_rd_nxt          = 1'b0;
    w_wdata_nxt       = '0;
    w_except_nxt      = 1'b0;
    unique case (w_state_nxt)
      S_T_RD_MST, S_R_RD_MST: begin
        w_rd_nxt     = 1'b1;
        w_addr_nxt   = CSR_MSTATUS;
        w_except_nxt = 1'b1;
      end
      S_T_WR_MEPC: begin
        w_wr_nxt    = 1'b1;
        w_addr_nxt  = CSR_MEPC;
        w_wdata_nxt = {r_pc[XLEN-1:2], 2'b00};
      end
      S_T_WR_MCAUSE: begin
        w_wr_nxt    = 1'b1;
        w_addr_nxt  = CSR_MCAUSE;
        w_wdata_nxt = r_cause;
      end
      S_T_WR_MST: begin
        w_wr_nxt    = 1'b1;
        w_addr_nxt  = CSR_MSTATUS;
        w_wdata_nxt = w_mst_trap;
      end
      S_T_RD_MTVEC: begin
        w_rd_nxt     = 1'b1;
        w_addr_nxt   = CSR_MTVEC;
        w_except_nxt = 1'b1;
      end
      S_R_RD_MEPC: begin
        w_rd_nxt     = 1'b1;
        w_addr_nxt   = CSR_MEPC;
        w_except_nxt = 1'b1;
      end
      S_R_WR_MST: begin
        w_wr_nxt    = 1'b1;
        w_addr_nxt  = CSR_MSTATUS;
        w_wdata_nxt = w_mst_ret;
      end
      S_REDIRECT: begin
        w_redirect_nxt    = 1'b1;
        w_redirect_pc_nxt = (r_state == S_T_CAP_MTVEC) ? w_trap_pc
                                                       : {r_tvec[XLEN-1:2], 2'b00};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      busy_o        <= 1'b0;
      redirect_o    <= 1'b0;
      redirect_pc_o <= '0;
      csr_addr_o    <= '0;
      csr_wr_o      <= 1'b0;
      csr_rd_o      <= 1'b0;
      csr_wdata_o   <= '0;
      csr_except_o  <= 1'b0;
    end else begin
      busy_o        <= w_busy_nxt;
      redirect_o    <= w_redirect_nxt;
      redirect_pc_o <= w_redirect_pc_nxt;
      csr_addr_o    <= w_addr_nxt;
      csr_wr_o      <= w_wr_nxt;
      csr_rd_o      <= w_rd_nxt;
      csr_wdata_o   <= w_wdata_nxt;
      csr_except_o  <= w_except_nxt;
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: a small CSR-file model with registered read, latency/target checks,
// mid-sequence reset, vectored mode (TRAP_VECTORED_EN) and a randomized port-protocol sweep.
module tb_trap_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        exc_valid_i = 1'b0;
  logic [31:0] exc_cause_i = '0;
  logic [31:0] exc_pc_i = '0;
  logic        mret_i = 1'b0;
  logic        busy_o;
  logic        redirect_o;
  logic [31:0] redirect_pc_o;
  logic [31:0] csr_addr_o;
  logic        csr_wr_o;
  logic        csr_rd_o;
  logic [31:0] csr_wdata_o;
  logic        csr_except_o;
  logic [31:0] csr_rdata_i;

  trap_ctrl #(.XLEN(32), .RD_LAT(1)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .exc_valid_i  (exc_valid_i),
    .exc_cause_i  (exc_cause_i),
    .exc_pc_i     (exc_pc_i),
    .mret_i       (mret_i),
    .busy_o       (busy_o),
    .redirect_o   (redirect_o),
    .redirect_pc_o(redirect_pc_o),
    .csr_addr_o   (csr_addr_o),
    .csr_wr_o     (csr_wr_o),
    .csr_rd_o     (csr_rd_o),
    .csr_wdata_o  (csr_wdata_o),
    .csr_except_o (csr_except_o),
    .csr_rdata_i  (csr_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // CSR file model: registered read, direct write, plus a bench-side preload port.
  logic [31:0] m_mstatus = '0, m_mtvec = '0, m_mepc = '0, m_mcause = '0;
  logic        ld = 1'b0;
  logic [31:0] ld_mst, ld_tvec, ld_mepc, ld_mcause;

  always @(posedge clk_i) begin
    if (ld) begin
      m_mstatus <= ld_mst;
      m_mtvec   <= ld_tvec;
      m_mepc    <= ld_mepc;
      m_mcause  <= ld_mcause;
    end else begin
      csr_rdata_i <= 32'hBAD0_BAD0;
      if (csr_rd_o) begin
        case (csr_addr_o)
          32'h300: csr_rdata_i <= m_mstatus;
          32'h305: csr_rdata_i <= m_mtvec;
          32'h341: csr_rdata_i <= m_mepc;
          32'h342: csr_rdata_i <= m_mcause;
          default: csr_rdata_i <= 32'h0;
        endcase
      end
      if (csr_wr_o) begin
        case (csr_addr_o)
          32'h300: m_mstatus <= csr_wdata_o;
          32'h305: m_mtvec   <= csr_wdata_o;
          32'h341: m_mepc    <= csr_wdata_o;
          32'h342: m_mcause  <= csr_wdata_o;
          default: ;
        endcase
      end
    end
  end

  // Protocol monitor, sampled mid-cycle.
  int   redir_count = 0;
  int   proto_err = 0;
  logic prev_redir = 1'b0;
  always @(negedge clk_i) begin
    if (rst_i) begin
      if (csr_wr_o && csr_rd_o) proto_err++;
      if (csr_wr_o && csr_except_o) proto_err++;
      if (redirect_o && prev_redir) proto_err++;
      if (redirect_o) redir_count++;
      prev_redir = redirect_o;
    end else begin
      prev_redir = 1'b0;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic preload(input logic [31:0] mst, input logic [31:0] tvec,
                         input logic [31:0] mepc, input logic [31:0] mcause);
    @(negedge clk_i);
    ld = 1'b1; ld_mst = mst; ld_tvec = tvec; ld_mepc = mepc; ld_mcause = mcause;
    @(negedge clk_i);
    ld = 1'b0;
  endtask

  // Presents one request for one edge; cycle 1 is the cycle after the accept edge.
  // poke_cyc re-raises exc_valid_i for one cycle while the sequence is busy (0 = never).
  task automatic launch(input logic e, input logic m, input logic [31:0] cause,
                        input logic [31:0] pc, input int poke_cyc,
                        output int rcyc, output logic [31:0] rpc, output int bcnt);
    rcyc = 0; rpc = '0; bcnt = 0;
    @(negedge clk_i);
    exc_valid_i = e; mret_i = m; exc_cause_i = cause; exc_pc_i = pc;
    @(negedge clk_i);
    exc_valid_i = 1'b0; mret_i = 1'b0;
    for (int cyc = 1; cyc <= 20 && rcyc == 0; cyc++) begin
      if (busy_o) bcnt++;
      if (redirect_o) begin
        rcyc = cyc;
        rpc  = redirect_pc_o;
      end
      exc_valid_i = (cyc == poke_cyc);
      @(negedge clk_i);
    end
    exc_valid_i = 1'b0;
  endtask

  function automatic logic [31:0] trap_target(input logic [31:0] tvec, input logic [31:0] cause);
    logic [31:0] t;
    t = {tvec[31:2], 2'b00};
`ifdef TRAP_VECTORED_EN
    if (tvec[1:0] == 2'b01 && cause[31]) t = t + {25'd0, cause[4:0], 2'b00};
`endif
    return t;
  endfunction

  function automatic logic [31:0] mst_after_trap(input logic [31:0] s);
    logic [31:0] r;
    r = s; r[7] = s[3]; r[3] = 1'b0; r[12:11] = 2'b11;
    return r;
  endfunction

  function automatic logic [31:0] mst_after_mret(input logic [31:0] s);
    logic [31:0] r;
    r = s; r[3] = s[7]; r[7] = 1'b1; r[12:11] = 2'b11;
    return r;
  endfunction

  initial begin
    int          rcyc, bcnt, rc0, lat_bad, pc_bad, mst_bad;
    logic [31:0] rpc, exp_pc, exp_mst, cause, pc;
    logic        e, m;

    // Reset state
    repeat (3) @(negedge clk_i);
    check("reset_ctrl", {27'd0, busy_o, redirect_o, csr_wr_o, csr_rd_o, csr_except_o}, 32'h0);
    check("reset_addr", csr_addr_o, 32'h0);
    check("reset_wdata", csr_wdata_o, 32'h0);
    check("reset_rpc", redirect_pc_o, 32'h0);
    rst_i = 1'b1;

    // Exception
    preload(32'h0000_0008, 32'h0000_0100, 32'h0, 32'h0);
    launch(1'b1, 1'b0, 32'h2, 32'h0000_0406, 0, rcyc, rpc, bcnt);
    check("exc_latency", rcyc, 7);
    check("exc_target", rpc, 32'h0000_0100);
    check("exc_busy_cycles", bcnt, 7);
    check("exc_busy_after", {31'd0, busy_o}, 32'h0);
    check("exc_mepc", m_mepc, 32'h0000_0404);
    check("exc_mcause", m_mcause, 32'h2);
    check("exc_mstatus", m_mstatus, 32'h0000_1880);

    // MRET using the state the trap left behind
    launch(1'b0, 1'b1, 32'h0, 32'h0, 0, rcyc, rpc, bcnt);
    check("mret_latency", rcyc, 5);
    check("mret_target", rpc, 32'h0000_0404);
    check("mret_busy_cycles", bcnt, 5);
    check("mret_mstatus", m_mstatus, 32'h0000_1888);

    // Exception beats MRET; a request during busy is dropped
    preload(32'h0000_0008, 32'h0000_0100, 32'h0, 32'h0);
    rc0 = redir_count;
    launch(1'b1, 1'b1, 32'hB, 32'h0000_1000, 3, rcyc, rpc, bcnt);
    check("both_latency", rcyc, 7);
    check("both_mcause", m_mcause, 32'hB);
    repeat (12) @(negedge clk_i);
    check("both_one_redirect", redir_count - rc0, 1);
    check("both_idle", {31'd0, busy_o}, 32'h0);

    // Reset in the middle of T_WR_MCAUSE
    preload(32'h0, 32'h0000_0100, 32'h0, 32'h0000_DEAD);
    @(negedge clk_i);
    exc_valid_i = 1'b1; exc_cause_i = 32'h3; exc_pc_i = 32'h0000_0800;
    @(negedge clk_i);
    exc_valid_i = 1'b0;
    repeat (2) @(negedge clk_i);
    check("midrst_wr", {31'd0, csr_wr_o}, 32'h1);
    check("midrst_addr", csr_addr_o, 32'h342);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    check("midrst_ctrl", {27'd0, busy_o, redirect_o, csr_wr_o, csr_rd_o, csr_except_o}, 32'h0);
    check("midrst_addr0", csr_addr_o, 32'h0);
    check("midrst_wdata0", csr_wdata_o, 32'h0);
    @(negedge clk_i);
    rst_i = 1'b1;
    check("midrst_mcause_kept", m_mcause, 32'h0000_DEAD);
    launch(1'b1, 1'b0, 32'h5, 32'h0000_0900, 0, rcyc, rpc, bcnt);
    check("postrst_latency", rcyc, 7);
    check("postrst_target", rpc, 32'h0000_0100);
    check("postrst_mcause", m_mcause, 32'h5);

    // Vectored mode: interrupt with mode=01, then an exception with the same mtvec
    preload(32'h0, 32'h0000_0201, 32'h0, 32'h0);
    launch(1'b1, 1'b0, 32'h8000_0007, 32'h0000_0040, 0, rcyc, rpc, bcnt);
`ifdef TRAP_VECTORED_EN
    check("vec_irq_target", rpc, 32'h0000_021C);
`else
    check("vec_irq_target", rpc, 32'h0000_0200);
`endif
    preload(32'h0, 32'h0000_0201, 32'h0, 32'h0);
    launch(1'b1, 1'b0, 32'h0000_0007, 32'h0000_0040, 0, rcyc, rpc, bcnt);
    check("vec_exc_target", rpc, 32'h0000_0200);

    // Randomized protocol sweep
    rc0 = redir_count; lat_bad = 0; pc_bad = 0; mst_bad = 0;
    proto_err = 0;
    for (int i = 0; i < 1000; i++) begin
      ld_mst = $urandom; ld_tvec = $urandom; ld_mepc = $urandom;
      preload(ld_mst, ld_tvec, ld_mepc, 32'h0);
      e     = 1'($urandom_range(0, 1));
      m     = e ? 1'($urandom_range(0, 1)) : 1'b1;
      cause = $urandom;
      pc    = $urandom;
      if (e) begin
        exp_pc  = trap_target(ld_tvec, cause);
        exp_mst = mst_after_trap(ld_mst);
      end else begin
        exp_pc  = {ld_mepc[31:2], 2'b00};
        exp_mst = mst_after_mret(ld_mst);
      end
      launch(e, m, cause, pc, int'($urandom_range(0, 6)), rcyc, rpc, bcnt);
      if (rcyc != (e ? 7 : 5)) lat_bad++;
      if (rpc !== exp_pc) pc_bad++;
      if (m_mstatus !== exp_mst) mst_bad++;
    end
    repeat (4) @(negedge clk_i);
    check("rand_redirects", redir_count - rc0, 1000);
    check("rand_protocol", proto_err, 0);
    check("rand_latency", lat_bad, 0);
    check("rand_target", pc_bad, 0);
    check("rand_mstatus", mst_bad, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
